// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the
// control-bit bundle carried down the pipeline.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_fmt_e;

  // Field order is shared with execute/memory stages; append only.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: instruction bits + format -> sign-extended immediate.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [31:7]          instr,
  input  imm_fmt_e             fmt,
  output logic [DATAWIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = DATAWIDTH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives regfile read addresses, registers decoded
// fields/control, and inserts a one-cycle bubble on load-use hazards.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [DATAWIDTH-1:0] in_pc,
  input  logic                 stall,
  input  logic                 flush,
  output logic [4:0]           readReg1,
  output logic [4:0]           readReg2,
  output logic                 fetch_stall,
  output logic                 id_valid,
  output logic [DATAWIDTH-1:0] id_pc,
  output logic [4:0]           id_rs1,
  output logic [4:0]           id_rs2,
  output logic [4:0]           id_rd,
  output logic [DATAWIDTH-1:0] id_imm,
  output logic [2:0]           id_funct3,
  output logic                 id_funct7b5,
  output logic                 id_reg_write,
  output logic                 id_mem_read,
  output logic                 id_mem_write,
  output logic                 id_alu_src,
  output logic                 id_branch,
  output logic                 id_jump,
  output logic                 id_illegal
);

  typedef struct packed {
    logic                 valid;
    logic [DATAWIDTH-1:0] pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [DATAWIDTH-1:0] imm;
    logic [2:0]           funct3;
    logic                 funct7b5;
    ctrl_t                ctrl;
  } id_t;

  id_t                  id_q, id_d;
  ctrl_t                ctrl;
  imm_fmt_e             fmt;
  logic                 uses_rs1, uses_rs2, f7b5, hazard;
  logic [DATAWIDTH-1:0] imm;

  always_comb begin
    ctrl     = '0;
    fmt      = IMM_NONE;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    f7b5     = 1'b0;
    case (in_instr[6:0])
      OPC_OP:     begin ctrl.reg_write = 1'b1; uses_rs2 = 1'b1; f7b5 = in_instr[30]; end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_I;
        f7b5 = (in_instr[13:12] == 2'b01) && in_instr[30]; // SLLI/SRLI/SRAI only
      end
      OPC_LOAD:   begin ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_I; end
      OPC_STORE:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_S; uses_rs2 = 1'b1; end
      OPC_BRANCH: begin ctrl.branch = 1'b1; fmt = IMM_B; uses_rs2 = 1'b1; end
      OPC_JAL:    begin ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; fmt = IMM_J; uses_rs1 = 1'b0; end
      OPC_JALR:   begin ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_I; end
      OPC_LUI,
      OPC_AUIPC:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; fmt = IMM_U; uses_rs1 = 1'b0; end
      default:    ctrl.illegal = 1'b1;
    endcase
    if (in_instr[11:7] == 5'd0) ctrl.reg_write = 1'b0;
  end

  imm_gen #(.DATAWIDTH(DATAWIDTH)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign hazard = id_q.valid && id_q.ctrl.mem_read && (id_q.rd != 5'd0) && in_valid &&
                  ((uses_rs1 && (id_q.rd == in_instr[19:15])) ||
                   (uses_rs2 && (id_q.rd == in_instr[24:20])));

  always_comb begin
    id_d = id_q;
    if (flush) begin
      id_d.valid = 1'b0;
      id_d.ctrl  = '0;
    end else if (!stall) begin
      if (hazard) begin
        id_d.valid = 1'b0;
        id_d.ctrl  = '0;
      end else begin
        id_d.valid    = in_valid;
        id_d.pc       = in_pc;
        id_d.rs1      = in_instr[19:15];
        id_d.rs2      = in_instr[24:20];
        id_d.rd       = in_instr[11:7];
        id_d.imm      = imm;
        id_d.funct3   = in_instr[14:12];
        id_d.funct7b5 = f7b5;
        id_d.ctrl     = ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) id_q <= '0;
    else       id_q <= id_d;
  end

  // Stalled: keep re-reading the held sources so writeback stays visible.
  assign readReg1    = stall ? id_q.rs1 : in_instr[19:15];
  assign readReg2    = stall ? id_q.rs2 : in_instr[24:20];
  assign fetch_stall = stall || hazard;

  assign id_valid     = id_q.valid;
  assign id_pc        = id_q.pc;
  assign id_rs1       = id_q.rs1;
  assign id_rs2       = id_q.rs2;
  assign id_rd        = id_q.rd;
  assign id_imm       = id_q.imm;
  assign id_funct3    = id_q.funct3;
  assign id_funct7b5  = id_q.funct7b5;
  assign id_reg_write = id_q.ctrl.reg_write;
  assign id_mem_read  = id_q.ctrl.mem_read;
  assign id_mem_write = id_q.ctrl.mem_write;
  assign id_alu_src   = id_q.ctrl.alu_src;
  assign id_branch    = id_q.ctrl.branch;
  assign id_jump      = id_q.ctrl.jump;
  assign id_illegal   = id_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes reference-model
// expectations, a monitor pops and compares them against the DUT.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  readReg1, readReg2;
  logic        fetch_stall, id_valid;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_write, id_mem_read, id_mem_write;
  logic        id_alu_src, id_branch, id_jump, id_illegal;

  decode_stage #(.DATAWIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush), .readReg1(readReg1), .readReg2(readReg2),
    .fetch_stall(fetch_stall), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_jump(id_jump), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        f7b5;
    logic        reg_write, mem_read, mem_write, alu_src, branch, jump, illegal;
  } st_t;

  typedef struct {
    logic [4:0] rr1, rr2;
    logic       fs;
    st_t        nxt;
  } ent_t;

  ent_t q[$];
  st_t  m;
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sign-extend v from bit msb.
  function automatic logic [31:0] sx(input logic [31:0] v, input int msb);
    return 32'($signed(v << (31 - msb)) >>> (31 - msb));
  endfunction

  function automatic st_t decode(input logic v, input logic [31:0] i, input logic [31:0] pc);
    st_t s;
    s = '0;
    s.valid = v; s.pc = pc;
    s.rs1 = i[19:15]; s.rs2 = i[24:20]; s.rd = i[11:7]; s.funct3 = i[14:12];
    case (i[6:0])
      7'h33: begin s.reg_write = 1; s.f7b5 = i[30]; end
      7'h13: begin
        s.reg_write = 1; s.alu_src = 1; s.imm = sx(32'(i[31:20]), 11);
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) s.f7b5 = i[30];
      end
      7'h03: begin s.reg_write = 1; s.mem_read = 1; s.alu_src = 1; s.imm = sx(32'(i[31:20]), 11); end
      7'h23: begin s.mem_write = 1; s.alu_src = 1; s.imm = sx(32'(i[31:25]) * 32 + 32'(i[11:7]), 11); end
      7'h63: begin
        s.branch = 1;
        s.imm = sx(32'(i[31]) * 4096 + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2, 12);
      end
      7'h6F: begin
        s.reg_write = 1; s.jump = 1;
        s.imm = sx(32'(i[31]) * (1 << 20) + 32'(i[19:12]) * (1 << 12) + 32'(i[20]) * (1 << 11)
                   + 32'(i[30:21]) * 2, 20);
      end
      7'h67: begin s.reg_write = 1; s.jump = 1; s.alu_src = 1; s.imm = sx(32'(i[31:20]), 11); end
      7'h37, 7'h17: begin s.reg_write = 1; s.alu_src = 1; s.imm = i & 32'hFFFFF000; end
      default: s.illegal = 1;
    endcase
    if (s.rd == 0) s.reg_write = 0;
    return s;
  endfunction

  function automatic st_t kill(input st_t s);
    st_t r;
    r = s;
    r.valid = 0; r.reg_write = 0; r.mem_read = 0; r.mem_write = 0;
    r.alu_src = 0; r.branch = 0; r.jump = 0; r.illegal = 0;
    return r;
  endfunction

  // One clock of stimulus; expectation for this cycle is queued for the monitor.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic st, input logic fl);
    ent_t e;
    logic hz, u1, u2;
    @(negedge clk);
    reset = r; in_valid = v; in_instr = ins; in_pc = pc; stall = st; flush = fl;
    u1 = !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
    u2 = (ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63);
    hz = m.valid && m.mem_read && m.rd != 0 && v &&
         ((u1 && m.rd == ins[19:15]) || (u2 && m.rd == ins[24:20]));
    e.rr1 = st ? m.rs1 : ins[19:15];
    e.rr2 = st ? m.rs2 : ins[24:20];
    e.fs  = st || hz;
    if (r)       m = '0;
    else if (fl) m = kill(m);
    else if (!st) m = hz ? kill(m) : decode(v, ins, pc);
    e.nxt = m;
    q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    ent_t e;
    st_t  a;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("readReg1", 128'(readReg1), 128'(e.rr1));
        chk("readReg2", 128'(readReg2), 128'(e.rr2));
        chk("fetch_stall", 128'(fetch_stall), 128'(e.fs));
        @(posedge clk);
        #1;
        a = {id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_funct3, id_funct7b5,
             id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump, id_illegal};
        chk("id_state", 128'(a), 128'(e.nxt));
      end
    end
  end

  localparam logic [6:0] OPS [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                      7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B, 7'h30};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    i = $urandom;
    i[6:0]   = OPS[$urandom_range(0, 11)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin : driver
    logic [31:0] ri;
    m = '0;
    reset = 1; in_valid = 1; in_instr = NOP; in_pc = 0; stall = 0; flush = 0;
    @(posedge clk);

    // Reset held with valid input.
    step(1, 1, 32'hFFF00293, 32'h100, 0, 0);
    step(1, 1, 32'hFFF00293, 32'h100, 0, 0);
    step(0, 0, NOP, 32'h0, 0, 0);
    chk("reset_id_valid", 128'(id_valid), 128'(0));
    chk("reset_id_imm", 128'(id_imm), 128'(0));

    // addi x5, x0, -1
    step(0, 1, 32'hFFF00293, 32'h200, 0, 0);
    chk("addi_readReg1", 128'(readReg1), 128'(0));
    step(0, 0, NOP, 32'h0, 0, 0);
    chk("addi_rd", 128'(id_rd), 128'(5));
    chk("addi_imm", 128'(id_imm), 128'(32'hFFFFFFFF));
    chk("addi_ctrl", 128'({id_alu_src, id_reg_write}), 128'(2'b11));

    // lw x6,0(x1); add x7,x6,x2 -> one bubble
    step(0, 1, 32'h0000A303, 32'h300, 0, 0);
    step(0, 1, 32'h002303B3, 32'h304, 0, 0);
    chk("lu_fetch_stall", 128'(fetch_stall), 128'(1));
    step(0, 1, 32'h002303B3, 32'h304, 0, 0);
    chk("lu_bubble_valid", 128'(id_valid), 128'(0));
    chk("lu_no_repeat", 128'(fetch_stall), 128'(0));
    step(0, 0, NOP, 32'h0, 0, 0);
    chk("lu_add_valid", 128'(id_valid), 128'(1));
    chk("lu_add_rs1", 128'(id_rs1), 128'(6));

    // lw x6,0(x1); add x7,x1,x2 -> no bubble
    step(0, 1, 32'h0000A303, 32'h400, 0, 0);
    step(0, 1, 32'h002083B3, 32'h404, 0, 0);
    chk("nolu_fetch_stall", 128'(fetch_stall), 128'(0));
    step(0, 0, NOP, 32'h0, 0, 0);
    chk("nolu_add_valid", 128'(id_valid), 128'(1));
    chk("nolu_add_rs1", 128'(id_rs1), 128'(1));

    // beq x3,x4,+8 held by 3 stall cycles
    step(0, 1, 32'h00418463, 32'h500, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'h002083B3, 32'h504, 1, 0);
      chk("stall_readReg1", 128'(readReg1), 128'(3));
      chk("stall_readReg2", 128'(readReg2), 128'(4));
      chk("stall_held_imm", 128'({id_branch, id_imm}), 128'({1'b1, 32'd8}));
    end
    step(0, 1, 32'h002083B3, 32'h504, 0, 0);
    chk("stall_release_pc", 128'(id_pc), 128'(32'h500));

    // flush with stall kills the held load
    step(0, 1, 32'h0000A303, 32'h600, 0, 0);
    step(0, 1, NOP, 32'h604, 1, 1);
    step(0, 0, NOP, 32'h0, 0, 0);
    chk("flush_valid", 128'(id_valid), 128'(0));
    chk("flush_ctrl", 128'({id_reg_write, id_mem_read, id_alu_src}), 128'(0));

    // illegal opcodes and rd == x0
    step(0, 1, 32'h0000037F, 32'h700, 0, 0);
    step(0, 1, 32'h00000300, 32'h704, 0, 0);
    chk("illegal_7f", 128'({id_illegal, id_reg_write, id_mem_write}), 128'(3'b100));
    step(0, 1, 32'h00208033, 32'h708, 0, 0);
    chk("illegal_lsb00", 128'({id_illegal, id_reg_write, id_mem_write}), 128'(3'b100));
    step(0, 0, NOP, 32'h0, 0, 0);
    chk("add_x0_regwrite", 128'({id_valid, id_reg_write}), 128'(2'b10));

    // randomized traffic; fetch honours fetch_stall by re-presenting the instruction
    ri = rnd_instr();
    for (int n = 0; n < 600; n++) begin
      if (!fetch_stall || $urandom_range(0, 7) == 0) ri = rnd_instr();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 85, ri, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction-decode pipeline stage sitting directly upstream of `regfile`. It drives the register file's read addresses from the incoming instruction, so the regfile's one-cycle registered read lines up with this stage's registered decode fields on the same edge. It also decodes control and immediates, detects load-use hazards by inserting a bubble, and honours downstream stall and flush.

## Interface
- `DATAWIDTH`, 32: instruction, PC and immediate width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch presents a valid instruction.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: PC of `in_instr`.
- `stall` in 1: downstream cannot accept; hold all outputs.
- `flush` in 1: branch redirect; kill the held and incoming instruction.
- `readReg1` / `readReg2` out 5: regfile read addresses, combinational.
- `fetch_stall` out 1: fetch must hold `in_instr`/`in_pc` this cycle, combinational.
- `id_valid` out 1; `id_pc` out 32; `id_rs1`, `id_rs2`, `id_rd` out 5; `id_imm` out 32; `id_funct3` out 3; `id_funct7b5` out 1: registered decode fields.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_alu_src`, `id_branch`, `id_jump`, `id_illegal` out 1: registered control bits.

## Operation
- Accept condition: `accept = !stall && !hazard`. On accept, all `id_*` load from the decoded `in_instr`, and `id_valid <= in_valid`.
- Address mux: `readReg1/2 = stall ? id_rs1/id_rs2 : in_instr[19:15]/[24:20]`. While stalled, the regfile keeps re-reading the held instruction's sources, so writeback updates and regfile bypass stay visible.
- Load-use hazard: `hazard = id_valid && id_mem_read && id_rd != 0 && in_valid && ((uses_rs1 && id_rd == rs1) || (uses_rs2 && id_rd == rs2))`.
  - `uses_rs1` is false for LUI, AUIPC and JAL.
  - `uses_rs2` is true only for R-type, STORE and BRANCH.
- On hazard without stall: `id_valid <= 0` and all control bits are cleared (bubble). `fetch_stall = 1`. The instruction is accepted on the next cycle.
- `fetch_stall = stall || hazard`.
- Priority: `reset` > `flush` > `stall` > `hazard` > accept.
  - `flush`: `id_valid <= 0`, all control bits <= 0, `fetch_stall` is not forced.
  - Flush during stall: flush wins.
- Decode by opcode: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode, or `in_instr[1:0] != 2'b11`: `id_illegal = 1`, and reg_write/mem_read/mem_write/branch/jump all = 0.
- `id_reg_write` is forced to 0 when rd == 0.
- Immediates (I/S/B/U/J) are sign-extended to DATAWIDTH from bit 31. B and J set bit 0 to 0. U is `{instr[31:12], 12'b0}`. R-type imm = 0.
- `alu_src = 1` for OP-IMM, LOAD, STORE, JALR, LUI and AUIPC.
- `funct7b5 = instr[30]` for OP and for OP-IMM shifts (funct3 001/101), else 0.

## Timing
- Reset value of every `id_*` output is 0. `readReg1/2` show `in_instr` fields, since `stall` alone selects the mux. `fetch_stall` reflects the current `stall`.
- Latency is one cycle: instruction accepted at edge N → `id_*` and `regfile.readData1/2` are valid together after edge N.
- A bubble costs exactly one cycle. Back-to-back load-use chains insert one bubble per dependent pair.
- `stall` held for K cycles holds `id_*` for K cycles with no loss or duplication.
- `hazard` is evaluated against the held `id_*`. While stalled, `hazard` is ignored.

## Structure
- `riscv_pkg` holds:
  - the opcode localparams (`OPC_OP = 7'b0110011`, etc.);
  - the immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE);
  - the shared control-bit field order for later stages.
- `imm_gen` sub-module: combinational instr + format → 32-bit immediate. Reused by the execute-stage branch target logic.
- Everything else stays in `decode_stage`.

## Test plan
- Reset: assert `reset` 2 cycles with `in_valid = 1` → all `id_*` = 0 and `id_valid = 0` after release until the first accept.
- `addi x5, x0, -1` (0xFFF00293) accepted → next cycle `id_rd = 5`, `id_imm = 0xFFFFFFFF`, `id_alu_src = 1`, `id_reg_write = 1`, `readReg1 = 0` during the accept cycle.
- `lw x6, 0(x1)` then `add x7, x6, x2` → one bubble (`id_valid = 0`, `fetch_stall = 1` for 1 cycle), then `add` is accepted with `id_rs1 = 6`. Same sequence with `add x7, x1, x2` → no bubble.
- Hold `stall` 3 cycles with `beq` held → `id_*` unchanged and `readReg1/2` = held rs1/rs2. In cycle 2, a regfile write to rs1 → `readData1` shows the new value the following cycle.
- `flush` and `stall` asserted together → next cycle `id_valid = 0` and all control bits = 0.
- Opcode 0x7F, and `instr[1:0] = 2'b00` → `id_illegal = 1`, `id_reg_write = id_mem_write = 0`. `add x0, x1, x2` → `id_reg_write = 0`.
